// File: rtl/tile_positioner_pkg.sv
// Shared definitions for the tile positioner: default widths, FSM encoding,
// and the stride normalisation helper.
package tile_positioner_pkg;

    localparam int DEF_COORD_W = 8;
    localparam int DEF_PAD_W   = 2;
    localparam int STRIDE_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLACE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A stride of zero is treated as a stride of one.
    function automatic logic [STRIDE_W-1:0] norm_stride(input logic [STRIDE_W-1:0] s);
        logic [STRIDE_W-1:0] r;
        if (s == {STRIDE_W{1'b0}}) begin
            r = STRIDE_W'(1'b1);
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/tile_positioner_axis_stepper.sv
// One axis of the centre walk. Holds the current coordinate and reports
// whether it is the last centre on this axis; stepping past the last centre
// wraps back to the halo offset.
module tile_positioner_axis_stepper
    import tile_positioner_pkg::*;
#(
    parameter int EXT_W = 9
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [EXT_W-1:0]    load_value,
    input  logic [EXT_W-1:0]    halo,
    input  logic [EXT_W-1:0]    limit,
    input  logic [STRIDE_W-1:0] stride,
    output logic [EXT_W-1:0]    coord,
    output logic                last
);

    logic [EXT_W:0]   sum_s;
    logic [EXT_W-1:0] next_s;
    logic [EXT_W-1:0] coord_r;

    // Next coordinate one extra bit wide so the end-of-axis test cannot wrap.
    always_comb begin
        sum_s = {1'b0, coord_r} + (EXT_W+1)'(stride);
        last  = (sum_s > {1'b0, limit});
        if (last) begin
            next_s = halo;
        end else begin
            next_s = sum_s[EXT_W-1:0];
        end
    end

    // Coordinate register: load at layer start, step while placing.
    always_ff @(posedge clk) begin
        if (rst) begin
            coord_r <= {EXT_W{1'b0}};
        end else if (load) begin
            coord_r <= load_value;
        end else if (step) begin
            coord_r <= next_s;
        end else begin
            coord_r <= coord_r;
        end
    end

    assign coord = coord_r;

endmodule

// File: rtl/tile_positioner.sv
// Allocator positioner: walks filter centres over a padded image in raster
// order, hands one centre per cycle to NUM_ALLOC allocators in rounds, and
// publishes each round's pixel bounding box before waiting for advance.
module tile_positioner
    import tile_positioner_pkg::*;
#(
    parameter int NUM_ALLOC = 220,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int PAD_W     = DEF_PAD_W,
    parameter int CNT_W     = $clog2(NUM_ALLOC + 1)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [COORD_W-1:0]   img_w,
    input  logic [COORD_W-1:0]   img_h,
    input  logic [PAD_W-1:0]     pad,
    input  logic [PAD_W-1:0]     halo,
    input  logic [STRIDE_W-1:0]  stride,
    input  logic                 advance,
    output logic [COORD_W-1:0]   center_x,
    output logic [COORD_W-1:0]   center_y,
    output logic [NUM_ALLOC-1:0] alloc_sel,
    output logic                 alloc_valid,
    output logic [COORD_W-1:0]   x_min,
    output logic [COORD_W-1:0]   x_max,
    output logic [COORD_W-1:0]   y_min,
    output logic [COORD_W-1:0]   y_max,
    output logic [CNT_W-1:0]     round_count,
    output logic                 round_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int EXT_W = COORD_W + 1;

    // Clamp an extended value into the output coordinate range.
    function automatic logic [COORD_W-1:0] sat_coord(input logic [EXT_W-1:0] v);
        logic [COORD_W-1:0] r;
        if (v[COORD_W]) begin
            r = {COORD_W{1'b1}};
        end else begin
            r = v[COORD_W-1:0];
        end
        return r;
    endfunction

    state_t state_r, next_state_s;

    logic [EXT_W-1:0]    pad_ext_s, halo_ext_s, span_s;
    logic [EXT_W-1:0]    padded_w_s, padded_h_s, limit_x_in_s, limit_y_in_s;
    logic                empty_s, load_s;

    logic [EXT_W-1:0]    halo_r, limit_x_r, limit_y_r;
    logic [STRIDE_W-1:0] stride_r;

    logic [EXT_W-1:0]    x_coord_s, y_coord_s;
    logic                x_last_s, y_last_s, layer_last_s, round_full_s;
    logic                step_x_s, step_y_s, enter_place_s;
    logic                layer_end_r;

    logic [CNT_W-1:0]     counter_r;
    logic [NUM_ALLOC-1:0] sel_r;
    logic [COORD_W-1:0]   x_min_r, x_max_r, y_min_r, y_max_r;
    logic [COORD_W-1:0]   x_lo_s, x_hi_s, y_lo_s, y_hi_s;

    logic valid_r, ready_r, busy_r, done_r;
    logic out_valid_s, out_ready_s, out_busy_s, out_done_s;

    // Geometry of the incoming configuration, used only when start is taken.
    always_comb begin
        pad_ext_s    = EXT_W'(pad);
        halo_ext_s   = EXT_W'(halo);
        span_s       = halo_ext_s + halo_ext_s + EXT_W'(1'b1);
        padded_w_s   = EXT_W'(img_w) + pad_ext_s + pad_ext_s;
        padded_h_s   = EXT_W'(img_h) + pad_ext_s + pad_ext_s;
        empty_s      = (padded_w_s < span_s) || (padded_h_s < span_s);
        limit_x_in_s = padded_w_s - EXT_W'(1'b1) - halo_ext_s;
        limit_y_in_s = padded_h_s - EXT_W'(1'b1) - halo_ext_s;
        load_s       = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    end

    // Configuration latch: captured only when a layer start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            halo_r    <= {EXT_W{1'b0}};
            limit_x_r <= {EXT_W{1'b0}};
            limit_y_r <= {EXT_W{1'b0}};
            stride_r  <= STRIDE_W'(1'b1);
        end else if (load_s) begin
            halo_r    <= halo_ext_s;
            limit_x_r <= limit_x_in_s;
            limit_y_r <= limit_y_in_s;
            stride_r  <= norm_stride(stride);
        end else begin
            halo_r    <= halo_r;
            limit_x_r <= limit_x_r;
            limit_y_r <= limit_y_r;
            stride_r  <= stride_r;
        end
    end

    // x steps on every placement; y steps only when x wraps.
    always_comb begin
        step_x_s     = (state_r == ST_PLACE);
        step_y_s     = (state_r == ST_PLACE) && x_last_s;
        layer_last_s = x_last_s && y_last_s;
        round_full_s = (counter_r == CNT_W'(NUM_ALLOC - 1));
    end

    tile_positioner_axis_stepper #(.EXT_W(EXT_W)) u_step_x (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .step       (step_x_s),
        .load_value (halo_ext_s),
        .halo       (halo_r),
        .limit      (limit_x_r),
        .stride     (stride_r),
        .coord      (x_coord_s),
        .last       (x_last_s)
    );

    tile_positioner_axis_stepper #(.EXT_W(EXT_W)) u_step_y (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .step       (step_y_s),
        .load_value (halo_ext_s),
        .halo       (halo_r),
        .limit      (limit_y_r),
        .stride     (stride_r),
        .coord      (y_coord_s),
        .last       (y_last_s)
    );

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (empty_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_PLACE;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_PLACE: begin
                if (layer_last_s || round_full_s) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_PLACE;
                end
            end
            ST_WAIT: begin
                if (advance) begin
                    if (layer_end_r) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_PLACE;
                    end
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode from the upcoming state so the flags come out of flops.
    always_comb begin
        out_valid_s = 1'b0;
        out_ready_s = 1'b0;
        out_busy_s  = 1'b0;
        out_done_s  = 1'b0;
        case (next_state_s)
            ST_PLACE: begin
                out_valid_s = 1'b1;
                out_busy_s  = 1'b1;
            end
            ST_WAIT: begin
                out_ready_s = 1'b1;
                out_busy_s  = 1'b1;
            end
            ST_DONE:  out_done_s = 1'b1;
            ST_IDLE:  out_done_s = 1'b0;
            default:  out_done_s = 1'b0;
        endcase
    end

    // FSM state register with the registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            valid_r <= out_valid_s;
            ready_r <= out_ready_s;
            busy_r  <= out_busy_s;
            done_r  <= out_done_s;
        end
    end

    // Remembers that the final layer position has been placed.
    always_ff @(posedge clk) begin
        if (rst) begin
            layer_end_r <= 1'b0;
        end else if (load_s) begin
            layer_end_r <= 1'b0;
        end else if ((state_r == ST_PLACE) && layer_last_s) begin
            layer_end_r <= 1'b1;
        end else begin
            layer_end_r <= layer_end_r;
        end
    end

    // Pixel extent of the centre currently presented.
    always_comb begin
        x_lo_s        = sat_coord(x_coord_s - halo_r);
        x_hi_s        = sat_coord(x_coord_s + halo_r);
        y_lo_s        = sat_coord(y_coord_s - halo_r);
        y_hi_s        = sat_coord(y_coord_s + halo_r);
        enter_place_s = (next_state_s == ST_PLACE) && (state_r != ST_PLACE);
    end

    // Slot counter, one-hot select shifter and per-round bounding box.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_r <= {CNT_W{1'b0}};
            sel_r     <= {NUM_ALLOC{1'b0}};
            x_min_r   <= {COORD_W{1'b1}};
            x_max_r   <= {COORD_W{1'b0}};
            y_min_r   <= {COORD_W{1'b0}};
            y_max_r   <= {COORD_W{1'b0}};
        end else if (enter_place_s) begin
            counter_r <= {CNT_W{1'b0}};
            sel_r     <= NUM_ALLOC'(1'b1);
            x_min_r   <= {COORD_W{1'b1}};
            x_max_r   <= {COORD_W{1'b0}};
            y_min_r   <= {COORD_W{1'b0}};
            y_max_r   <= {COORD_W{1'b0}};
        end else if (state_r == ST_PLACE) begin
            counter_r <= counter_r + CNT_W'(1'b1);
            if (next_state_s == ST_PLACE) begin
                sel_r <= sel_r << 1'b1;
            end else begin
                sel_r <= {NUM_ALLOC{1'b0}};
            end
            x_min_r <= (x_lo_s < x_min_r) ? x_lo_s : x_min_r;
            x_max_r <= (x_hi_s > x_max_r) ? x_hi_s : x_max_r;
            y_min_r <= (counter_r == {CNT_W{1'b0}}) ? y_lo_s : y_min_r;
            y_max_r <= y_hi_s;
        end else begin
            counter_r <= counter_r;
            sel_r     <= {NUM_ALLOC{1'b0}};
            x_min_r   <= x_min_r;
            x_max_r   <= x_max_r;
            y_min_r   <= y_min_r;
            y_max_r   <= y_max_r;
        end
    end

    assign center_x    = sat_coord(x_coord_s);
    assign center_y    = sat_coord(y_coord_s);
    assign alloc_sel   = sel_r;
    assign alloc_valid = valid_r;
    assign x_min       = x_min_r;
    assign x_max       = x_max_r;
    assign y_min       = y_min_r;
    assign y_max       = y_max_r;
    assign round_count = counter_r;
    assign round_ready = ready_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_tile_positioner.sv
// Testbench for tile_positioner: two instances (220 and 8 allocators) share
// the stimulus; a probe mux selects which one a test observes.
module tb_tile_positioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       advance = 1'b0;
    logic [7:0] img_w = 8'd0;
    logic [7:0] img_h = 8'd0;
    logic [1:0] pad = 2'd0;
    logic [1:0] halo = 2'd0;
    logic [2:0] stride = 3'd1;

    logic [7:0]   a_cx, a_cy, a_xmin, a_xmax, a_ymin, a_ymax, a_rc;
    logic [219:0] a_sel;
    logic         a_valid, a_ready, a_busy, a_done;
    logic [7:0]   b_cx, b_cy, b_xmin, b_xmax, b_ymin, b_ymax;
    logic [3:0]   b_rc;
    logic [7:0]   b_sel;
    logic         b_valid, b_ready, b_busy, b_done;

    tile_positioner #(.NUM_ALLOC(220)) dut_a (
        .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
        .pad(pad), .halo(halo), .stride(stride), .advance(advance),
        .center_x(a_cx), .center_y(a_cy), .alloc_sel(a_sel), .alloc_valid(a_valid),
        .x_min(a_xmin), .x_max(a_xmax), .y_min(a_ymin), .y_max(a_ymax),
        .round_count(a_rc), .round_ready(a_ready), .busy(a_busy), .done(a_done)
    );

    tile_positioner #(.NUM_ALLOC(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
        .pad(pad), .halo(halo), .stride(stride), .advance(advance),
        .center_x(b_cx), .center_y(b_cy), .alloc_sel(b_sel), .alloc_valid(b_valid),
        .x_min(b_xmin), .x_max(b_xmax), .y_min(b_ymin), .y_max(b_ymax),
        .round_count(b_rc), .round_ready(b_ready), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    bit use_b = 1'b0;
    int p_valid, p_cx, p_cy, p_xmin, p_xmax, p_ymin, p_ymax, p_rc;
    int p_ready, p_busy, p_done, p_ones, p_idx;

    // Probe mux: the observed instance's outputs as plain integers.
    always_comb begin
        p_ones = 0;
        p_idx  = -1;
        if (use_b) begin
            p_valid = int'(b_valid); p_cx = int'(b_cx); p_cy = int'(b_cy);
            p_xmin = int'(b_xmin); p_xmax = int'(b_xmax);
            p_ymin = int'(b_ymin); p_ymax = int'(b_ymax); p_rc = int'(b_rc);
            p_ready = int'(b_ready); p_busy = int'(b_busy); p_done = int'(b_done);
            for (int i = 0; i < 8; i++) begin
                if (b_sel[i]) begin p_ones = p_ones + 1; p_idx = i; end
            end
        end else begin
            p_valid = int'(a_valid); p_cx = int'(a_cx); p_cy = int'(a_cy);
            p_xmin = int'(a_xmin); p_xmax = int'(a_xmax);
            p_ymin = int'(a_ymin); p_ymax = int'(a_ymax); p_rc = int'(a_rc);
            p_ready = int'(a_ready); p_busy = int'(a_busy); p_done = int'(a_done);
            for (int i = 0; i < 220; i++) begin
                if (a_sel[i]) begin p_ones = p_ones + 1; p_idx = i; end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int w, input int h, input int pd, input int hl, input int st);
        img_w  = 8'(w);
        img_h  = 8'(h);
        pad    = 2'(pd);
        halo   = 2'(hl);
        stride = 3'(st);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit dut_b;
        int w, h, pad, halo, stride;
        int npos, nrounds, last_x, last_y;
        int r1_cnt, r1_xmin, r1_xmax, r1_ymin, r1_ymax;
        int rl_cnt, rl_xmin, rl_xmax, rl_ymin, rl_ymax;
    } vec_t;

    vec_t vecs[8];

    // Run one layer from reset, answering every round_ready with advance.
    task automatic run_vec(input int vi);
        vec_t v;
        int slot, pos, rounds, cycles, lx, ly, seq_err;
        int r1c, r1x0, r1x1, r1y0, r1y1, rlc, rlx0, rlx1, rly0, rly1;
        bit in_round, timed_out;
        string tag;
        v = vecs[vi];
        tag = $sformatf("v%0d", vi);
        slot = 0; pos = 0; rounds = 0; cycles = 0; lx = -1; ly = -1; seq_err = 0;
        r1c = -1; r1x0 = -1; r1x1 = -1; r1y0 = -1; r1y1 = -1;
        rlc = -1; rlx0 = -1; rlx1 = -1; rly0 = -1; rly1 = -1;
        in_round = 1'b0;
        timed_out = 1'b1;
        use_b = v.dut_b;
        do_reset();
        set_cfg(v.w, v.h, v.pad, v.halo, v.stride);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (v.npos == 0) begin
            check({tag, " empty_done_latency"}, p_done, 1);
        end else begin
            check({tag, " start_latency"}, p_valid, 1);
        end
        while (cycles < 1000) begin
            if (p_valid != 0) begin
                if (p_ones != 1 || p_idx != slot) seq_err++;
                lx = p_cx; ly = p_cy;
                slot++; pos++;
                in_round = 1'b1;
            end else if (p_ready != 0) begin
                rounds++;
                if (p_rc != slot) seq_err++;
                if (rounds == 1) begin
                    r1c = p_rc; r1x0 = p_xmin; r1x1 = p_xmax; r1y0 = p_ymin; r1y1 = p_ymax;
                end
                rlc = p_rc; rlx0 = p_xmin; rlx1 = p_xmax; rly0 = p_ymin; rly1 = p_ymax;
                slot = 0;
                in_round = 1'b0;
                advance = 1'b1;
            end else if (p_done != 0) begin
                if (in_round) seq_err++;
                timed_out = 1'b0;
                break;
            end else begin
                seq_err++;
            end
            tick();
            advance = 1'b0;
            cycles++;
        end
        advance = 1'b0;
        check({tag, " timeout"}, int'(timed_out), 0);
        check({tag, " positions"}, pos, v.npos);
        check({tag, " rounds"}, rounds, v.nrounds);
        check({tag, " sequencing_errors"}, seq_err, 0);
        if (v.npos > 0) begin
            check({tag, " last_cx"}, lx, v.last_x);
            check({tag, " last_cy"}, ly, v.last_y);
            check({tag, " r1_count"}, r1c, v.r1_cnt);
            check({tag, " r1_xmin"}, r1x0, v.r1_xmin);
            check({tag, " r1_xmax"}, r1x1, v.r1_xmax);
            check({tag, " r1_ymin"}, r1y0, v.r1_ymin);
            check({tag, " r1_ymax"}, r1y1, v.r1_ymax);
            check({tag, " last_round_count"}, rlc, v.rl_cnt);
            check({tag, " last_xmin"}, rlx0, v.rl_xmin);
            check({tag, " last_xmax"}, rlx1, v.rl_xmax);
            check({tag, " last_ymin"}, rly0, v.rl_ymin);
            check({tag, " last_ymax"}, rly1, v.rl_ymax);
        end
    endtask

    initial begin
        int err;
        //            B  w  h pd hl st  npos nr lx ly  r1: cnt x0 x1 y0 y1  last: cnt x0 x1 y0 y1
        vecs[0] = '{1'b0, 5, 5, 1, 1, 1, 25, 1, 5, 5, 25, 0, 6, 0, 6, 25, 0, 6, 0, 6};
        vecs[1] = '{1'b1, 4, 4, 1, 1, 1, 16, 2, 4, 4,  8, 0, 5, 0, 3,  8, 0, 5, 2, 5};
        vecs[2] = '{1'b0, 6, 6, 1, 1, 2,  9, 1, 5, 5,  9, 0, 6, 0, 6,  9, 0, 6, 0, 6};
        vecs[3] = '{1'b0, 3, 3, 0, 1, 1,  1, 1, 1, 1,  1, 0, 2, 0, 2,  1, 0, 2, 0, 2};
        vecs[4] = '{1'b0, 2, 2, 0, 1, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[5] = '{1'b1, 5, 3, 0, 1, 0,  3, 1, 3, 1,  3, 0, 4, 0, 2,  3, 0, 4, 0, 2};
        vecs[6] = '{1'b1, 5, 5, 0, 0, 2,  9, 2, 4, 4,  8, 0, 4, 0, 4,  1, 4, 4, 4, 4};
        vecs[7] = '{1'b1, 9, 2, 0, 0, 3,  3, 1, 6, 0,  3, 0, 6, 0, 0,  3, 0, 6, 0, 0};

        // Reset state.
        set_cfg(7, 7, 1, 1, 1);
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", int'(a_valid), 0);
        check("rst_sel_nonzero", int'(a_sel != '0), 0);
        check("rst_center_x", int'(a_cx), 0);
        check("rst_center_y", int'(a_cy), 0);
        check("rst_x_min", int'(a_xmin), 255);
        check("rst_x_max", int'(a_xmax), 0);
        check("rst_y_min", int'(a_ymin), 0);
        check("rst_y_max", int'(a_ymax), 0);
        check("rst_round_count", int'(a_rc), 0);
        check("rst_round_ready", int'(a_ready), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_b_x_min", int'(b_xmin), 255);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        // advance held high through PLACE is ignored (8 allocators, 4x4 pad1 halo1).
        use_b = 1'b1;
        do_reset();
        set_cfg(4, 4, 1, 1, 1);
        start = 1'b1;
        advance = 1'b1;
        tick();
        start = 1'b0;
        err = 0;
        for (int k = 0; k < 8; k++) begin
            if (p_valid != 1 || p_ones != 1 || p_idx != k) err++;
            tick();
        end
        check("advhold_place_errors", err, 0);
        check("advhold_wait_ready", p_ready, 1);
        check("advhold_wait_count", p_rc, 8);
        advance = 1'b0;
        tick();
        check("advhold_wait_holds", p_ready, 1);
        check("advhold_wait_no_valid", p_valid, 0);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check("advhold_r2_valid", p_valid, 1);
        check("advhold_r2_cx", p_cx, 1);
        check("advhold_r2_cy", p_cy, 3);
        check("advhold_r2_sel", p_idx, 0);

        // start ignored mid-layer, then rst on the 3rd PLACE cycle.
        use_b = 1'b0;
        do_reset();
        set_cfg(5, 5, 1, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midrst_c1_cx", p_cx, 1);
        tick();
        check("midrst_c2_cx", p_cx, 2);
        set_cfg(9, 9, 0, 2, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midrst_start_ignored_cx", p_cx, 3);
        check("midrst_start_ignored_cy", p_cy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", p_valid, 0);
        check("midrst_sel_ones", p_ones, 0);
        check("midrst_done", p_done, 0);
        check("midrst_busy", p_busy, 0);
        set_cfg(5, 5, 1, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_valid", p_valid, 1);
        check("restart_cx", p_cx, 1);
        check("restart_cy", p_cy, 1);
        check("restart_sel", p_idx, 0);

        // done is held, then start+advance together in DONE: start wins.
        do_reset();
        set_cfg(3, 3, 0, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("donehold_single_valid", p_valid, 1);
        tick();
        check("donehold_wait_ready", p_ready, 1);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check("donehold_done_latency", p_done, 1);
        tick();
        tick();
        check("donehold_done_held", p_done, 1);
        set_cfg(5, 5, 0, 0, 1);
        start = 1'b1;
        advance = 1'b1;
        tick();
        start = 1'b0;
        advance = 1'b0;
        check("donestart_valid", p_valid, 1);
        check("donestart_cx", p_cx, 0);
        check("donestart_done_cleared", p_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog in case a sequence stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
